// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter.
// Optional saturating mode is selected with COUNTER_SATURATE_EN.
package counter_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic logic [31:0] clamp_load(
        input logic [31:0] value,
        input logic [31:0] max
    );
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/counter_ifc.sv
// Signal bundle for the counter: DUT, TB and MONITOR views.
// MONITOR is sample-only; the TB drives controls after the clock edge.
interface counter_ifc
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic clk
);
    logic             rst;
    logic             en;
    logic             load;
    logic             up_down;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport DUT (
        input  clk, rst, en, load, up_down, data_in,
        output count, tc, wrap
    );

    modport TB (
        input  clk, count, tc, wrap,
        output rst, en, load, up_down, data_in
    );

    modport MONITOR (
        input clk, rst, en, load, up_down, data_in,
        input count, tc, wrap
    );

endinterface

// File: rtl/counter_next_state.sv
// Combinational next-count and wrap-event logic for the counter.
// COUNTER_SATURATE_EN turns wrap-around into hold-at-limit.
module counter_next_state
    import counter_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             load,
    input  logic             up_down,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count_nxt,
    output logic             wrap_nxt
);
    dir_e dir;
    assign dir = dir_e'(up_down);

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        priority case (1'b1)
            load: begin
                count_nxt = WIDTH'(clamp_load(32'(data_in), 32'(MAX_VAL)));
            end
            en && (dir == DIR_UP): begin
                if (count == MAX_VAL) begin
`ifdef COUNTER_SATURATE_EN
                    count_nxt = MAX_VAL;
`else
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
`endif
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end
            en && (dir == DIR_DOWN): begin
                if (count == '0) begin
`ifdef COUNTER_SATURATE_EN
                    count_nxt = '0;
`else
                    count_nxt = MAX_VAL;
                    wrap_nxt  = 1'b1;
`endif
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/counter_with_ifc.sv
// Up/down counter with clamped parallel load, tc and wrap pulse.
// Define COUNTER_SATURATE_EN for saturating instead of wrapping.
module counter_with_ifc
    import counter_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up_down,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    dir_e             dir;

    counter_next_state #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count     (count),
        .en        (en),
        .load      (load),
        .up_down   (up_down),
        .data_in   (data_in),
        .count_nxt (count_nxt),
        .wrap_nxt  (wrap_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

    // tc follows the current direction, not the enable
    assign dir = dir_e'(up_down);
    assign tc  = (dir == DIR_UP) ? (count == MAX_VAL) : (count == '0);

endmodule

// File: tb/tb_counter_with_ifc.sv
// Directed bench for counter_with_ifc, default and MAX_VAL=9 builds.
// Saturating expectations are used when COUNTER_SATURATE_EN is defined.
module tb_counter_with_ifc;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic       up_down;
    logic [3:0] data_in;
    logic [3:0] count;
    logic       tc;
    logic       wrap;
    logic [3:0] count9;
    logic       tc9;
    logic       wrap9;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_with_ifc #(.WIDTH(4)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .up_down (up_down),
        .data_in (data_in),
        .count   (count),
        .tc      (tc),
        .wrap    (wrap)
    );

    counter_with_ifc #(.WIDTH(4), .MAX_VAL(4'd9)) u_dut9 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .up_down (up_down),
        .data_in (data_in),
        .count   (count9),
        .tc      (tc9),
        .wrap    (wrap9)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; up_down = 1'b1; data_in = '0;
        #3;
        check("rst_count", 32'(count), 0);
        check("rst_wrap", 32'(wrap), 0);
        tick();
        rst = 1'b0;

        // async reset mid-count at 9
        load = 1'b1; data_in = 4'd9;
        tick();
        check("ld9_count", 32'(count), 9);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_count", 32'(count), 0);
        check("async_wrap", 32'(wrap), 0);
        rst = 1'b0;
        en = 1'b1; up_down = 1'b1;
        tick(); check("after_rst_1", 32'(count), 1);
        tick(); check("after_rst_2", 32'(count), 2);
        tick(); check("after_rst_3", 32'(count), 3);
        check("tc_mid", 32'(tc), 0);

`ifndef COUNTER_SATURATE_EN
        // up wrap
        en = 1'b0; load = 1'b1; data_in = 4'd14;
        tick(); check("upw_ld", 32'(count), 14);
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        tick();
        check("upw_c15", 32'(count), 15);
        check("upw_tc15", 32'(tc), 1);
        check("upw_w15", 32'(wrap), 0);
        tick();
        check("upw_c0", 32'(count), 0);
        check("upw_tc0", 32'(tc), 0);
        check("upw_w0", 32'(wrap), 1);
        tick();
        check("upw_c1", 32'(count), 1);
        check("upw_w1", 32'(wrap), 0);

        // down wrap
        en = 1'b0; load = 1'b1; data_in = 4'd1;
        tick(); check("dnw_ld", 32'(count), 1);
        load = 1'b0; en = 1'b1; up_down = 1'b0;
        tick();
        check("dnw_c0", 32'(count), 0);
        check("dnw_tc0", 32'(tc), 1);
        check("dnw_w0", 32'(wrap), 0);
        tick();
        check("dnw_c15", 32'(count), 15);
        check("dnw_tc15", 32'(tc), 0);
        check("dnw_w15", 32'(wrap), 1);
        tick();
        check("dnw_c14", 32'(count), 14);
        check("dnw_w14", 32'(wrap), 0);
`else
        // saturate at both ends
        en = 1'b0; load = 1'b1; data_in = 4'd15;
        tick(); check("sat_ld15", 32'(count), 15);
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        tick();
        check("sat_up1", 32'(count), 15);
        check("sat_up1_w", 32'(wrap), 0);
        check("sat_up1_tc", 32'(tc), 1);
        tick();
        check("sat_up2", 32'(count), 15);
        check("sat_up2_w", 32'(wrap), 0);
        en = 1'b0; load = 1'b1; data_in = 4'd0;
        tick(); check("sat_ld0", 32'(count), 0);
        load = 1'b0; en = 1'b1; up_down = 1'b0;
        tick();
        check("sat_dn1", 32'(count), 0);
        check("sat_dn1_w", 32'(wrap), 0);
        check("sat_dn1_tc", 32'(tc), 1);
        tick();
        check("sat_dn2", 32'(count), 0);
        check("sat_dn2_w", 32'(wrap), 0);
`endif

        // load beats enable, then hold
        load = 1'b1; en = 1'b1; up_down = 1'b1; data_in = 4'd5;
        tick();
        check("prio_count", 32'(count), 5);
        check("prio_wrap", 32'(wrap), 0);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("hold_c%0d", i), 32'(count), 5);
            check($sformatf("hold_w%0d", i), 32'(wrap), 0);
        end

        // tc ignores en, follows up_down combinationally
        load = 1'b1; data_in = 4'd15;
        tick();
        load = 1'b0; en = 1'b0; up_down = 1'b1;
        #1 check("tc_up15", 32'(tc), 1);
        up_down = 1'b0;
        #1 check("tc_dn15", 32'(tc), 0);

        // MAX_VAL = 9 clamping and wrap
        load = 1'b1; data_in = 4'd12; up_down = 1'b1;
        tick();
        check("m9_clamp", 32'(count9), 9);
        check("m9_noclamp", 32'(count), 12);
        check("m9_tc", 32'(tc9), 1);
        load = 1'b0; en = 1'b1;
        tick();
`ifndef COUNTER_SATURATE_EN
        check("m9_wrap_c", 32'(count9), 0);
        check("m9_wrap_w", 32'(wrap9), 1);
`else
        check("m9_sat_c", 32'(count9), 9);
        check("m9_sat_w", 32'(wrap9), 0);
`endif
        en = 1'b0;
        tick();
        check("m9_w_clear", 32'(wrap9), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
